fft8_sequencer: RTL and testbench
=================================

FFT8_SEQUENCER -- requirements
Module: fft8_sequencer

Interface
REQ-001 SHALL have parameter BF_LAT, default 2, butterfly-unit latency in cycles from issue to writeback; legal range 1..4.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; port list in the order below.
REQ-003 CLK  in  1  sole clock, rising edge.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 write  in  1  request to load the eight input samples into working memory.
REQ-006 start  in  1  request to run one 8-point transform on the loaded data.
REQ-007 ready  out  1  results valid in working memory.
REQ-008 busy  out  1  transform in progress.
REQ-009 load_en  out  1  one-cycle strobe to the sample memory, bit-reversed load.
REQ-010 bf_valid  out  1  butterfly issue strobe.
REQ-011 bf_addr_a, bf_addr_b  out  3 each  butterfly operand addresses.
REQ-012 tw_idx  out  2  twiddle exponent k, selecting W8^k.
REQ-013 bf_stage  out  2  current stage, 0..2.
REQ-014 bf_scale  out  1  divide-by-2 request for the issued butterfly.
REQ-015 wb_en  out  1  writeback strobe.
REQ-016 wb_addr_a, wb_addr_b  out  3 each  writeback addresses.
REQ-017 busy_err  out  1  sticky flag; write or start was received while busy.

Function
REQ-018 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-019 In IDLE or DONE, write=1 SHALL produce load_en=1 in the next cycle and clear ready.
REQ-020 In IDLE or DONE, start=1 SHALL enter RUN in the next cycle, clear ready and set busy.
REQ-021 When write and start are both asserted in the same cycle, the load SHALL happen first and RUN SHALL start in the same next cycle; the datapath treats the load as done within one cycle.
REQ-022 RUN SHALL issue 4 butterflies (k = 0..3) on consecutive cycles with bf_valid=1.
- After the 4th issue, the FSM SHALL go to DRAIN for BF_LAT cycles with bf_valid=0 (read-after-write hazard).
- After DRAIN, it SHALL go to RUN of the next stage, or to DONE after stage 2.
REQ-023 Addressing for stage s and butterfly k SHALL be:
- span = 2^s
- bf_addr_a = (k>>s)*2*span + (k & (span-1))
- bf_addr_b = bf_addr_a + span
- tw_idx = (k & (span-1)) << (2-s)
REQ-024 wb_en, wb_addr_a and wb_addr_b SHALL equal bf_valid, bf_addr_a and bf_addr_b delayed by exactly BF_LAT cycles.
REQ-025 Latency SHALL be 3*(4+BF_LAT)+1 cycles from the cycle start is sampled to ready=1. This is 19 cycles for BF_LAT=2.
REQ-026 In DONE, ready SHALL be 1 and busy 0; ready SHALL hold until a write or start is accepted.
REQ-027 While busy, write and start SHALL be ignored and busy_err SHALL be set; busy_err clears only on reset.
REQ-028 In IDLE, DONE and DRAIN, bf_valid, bf_addr_* and tw_idx SHALL be 0.

Reset
REQ-029 RST_N=0 SHALL asynchronously force IDLE and drive all outputs to 0, including the writeback delay line.
REQ-030 Reset asserted mid-transform SHALL abandon the transform; after release no wb_en from the abandoned issues SHALL appear.

Configuration
REQ-031 With macro FFT8_SCALE_EN defined, bf_scale SHALL equal bf_valid (scale by 1/2 each stage, 1/8 overall).
REQ-032 Without FFT8_SCALE_EN, bf_scale SHALL be tied to 0 and all other behaviour SHALL be unchanged.

Structure
REQ-033 Package fft8_pkg SHALL hold:
- constants N=8, LOG2N=3, BF_PER_STAGE=4
- the state enum
- address and twiddle index typedefs
REQ-034 The writeback delay SHALL be the sub-module fft8_wb_delay, a BF_LAT-deep shift register carrying valid and two addresses.

Verification (BF_LAT=2 unless stated; cycle 0 = the cycle start is sampled)
REQ-035 Reset, then write pulse -> load_en=1 for exactly one cycle; ready=0; busy=0.
REQ-036 start -> bf_valid at cycles 1-4, 7-10 and 13-16:
- stage 0 addr pairs (0,1)(2,3)(4,5)(6,7), tw 0,0,0,0
- stage 1 pairs (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2
- stage 2 pairs (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3
- wb_en at cycles 3-6, 9-12 and 15-18
- ready=1 at cycle 19
REQ-037 write and start in the same cycle from IDLE -> load_en and the first bf_valid pulse on the same cycle 1; ready at cycle 19.
REQ-038 start at cycle 8 of a run -> ignored, busy_err=1, ready still at cycle 19.
REQ-039 RST_N low at cycle 10, then released -> all outputs 0, no wb_en; a new start gives a full 19-cycle run.
REQ-040 BF_LAT=4 with FFT8_SCALE_EN defined -> ready at cycle 25 and bf_scale equal to bf_valid; without the macro, bf_scale stays 0.

Source files
------------

// File: rtl/fft8_pkg.sv
// Shared types, constants and addressing helpers for the 8-point FFT sequencer.
package fft8_pkg;

  localparam int N            = 8;
  localparam int LOG2N        = 3;
  localparam int BF_PER_STAGE = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [2:0] addr_t;   // working-memory address 0..7
  typedef logic [1:0] tw_t;     // twiddle exponent k of W8^k
  typedef logic [1:0] stage_t;  // stage 0..2
  typedef logic [1:0] bf_idx_t; // butterfly index within a stage, 0..3

  // Distance between the two operands of a butterfly in stage s.
  function automatic addr_t calc_span(input stage_t s);
    return addr_t'(3'd1 << s);
  endfunction

  // Upper operand address: groups of 2*span, offset within the group.
  function automatic addr_t calc_addr_a(input stage_t s, input bf_idx_t k);
    addr_t kk;
    addr_t span;
    kk   = {1'b0, k};
    span = calc_span(s);
    return ((kk >> s) << (s + 2'd1)) + (kk & (span - 3'd1));
  endfunction

  // Lower operand address sits one span above the upper one.
  function automatic addr_t calc_addr_b(input stage_t s, input bf_idx_t k);
    return calc_addr_a(s, k) + calc_span(s);
  endfunction

  // Twiddle exponent: position within the group scaled to the W8 grid.
  function automatic tw_t calc_tw(input stage_t s, input bf_idx_t k);
    addr_t kk;
    addr_t t;
    kk = {1'b0, k};
    t  = (kk & (calc_span(s) - 3'd1)) << (2'd2 - s);
    return t[1:0];
  endfunction

endpackage

// File: rtl/fft8_wb_delay.sv
// Writeback delay line: BF_LAT-deep shift register carrying the issue
// strobe and both operand addresses so writeback lines up with the
// butterfly unit's result.
module fft8_wb_delay
  import fft8_pkg::*;
#(
  parameter int BF_LAT = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       i_valid,
  input  logic [2:0] i_addr_a,
  input  logic [2:0] i_addr_b,
  output logic       o_valid,
  output logic [2:0] o_addr_a,
  output logic [2:0] o_addr_b
);

  logic  [BF_LAT-1:0] r_valid;
  addr_t              r_addr_a [BF_LAT];
  addr_t              r_addr_b [BF_LAT];

  // Shift the issue record one slot per cycle; reset flushes every slot so
  // nothing from an abandoned transform is ever written back.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_valid <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        r_addr_a[i] <= 3'd0;
        r_addr_b[i] <= 3'd0;
      end
    end else begin
      r_valid[0]  <= i_valid;
      r_addr_a[0] <= i_addr_a;
      r_addr_b[0] <= i_addr_b;
      for (int i = 1; i < BF_LAT; i++) begin
        r_valid[i]  <= r_valid[i-1];
        r_addr_a[i] <= r_addr_a[i-1];
        r_addr_b[i] <= r_addr_b[i-1];
      end
    end
  end

  assign o_valid  = r_valid[BF_LAT-1];
  assign o_addr_a = r_addr_a[BF_LAT-1];
  assign o_addr_b = r_addr_b[BF_LAT-1];

endmodule

// File: rtl/fft8_sequencer.sv
// Control sequencer for an in-place radix-2 8-point FFT.
// Issues 4 butterflies per stage over 3 stages, drains BF_LAT cycles between
// stages to avoid read-after-write hazards, and replays the issue stream
// BF_LAT cycles later as writeback strobes.
// Optional build macro: FFT8_SCALE_EN -- when defined, bf_scale follows
// bf_valid (divide by 2 per stage); otherwise bf_scale is held at 0.
module fft8_sequencer
  import fft8_pkg::*;
#(
  parameter int BF_LAT = 2  // butterfly latency, legal range 1..4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       write,
  input  logic       start,
  output logic       ready,
  output logic       busy,
  output logic       load_en,
  output logic       bf_valid,
  output logic [2:0] bf_addr_a,
  output logic [2:0] bf_addr_b,
  output logic [1:0] tw_idx,
  output logic [1:0] bf_stage,
  output logic       bf_scale,
  output logic       wb_en,
  output logic [2:0] wb_addr_a,
  output logic [2:0] wb_addr_b,
  output logic       busy_err
);

  localparam logic [1:0] DRAIN_LAST = 2'(BF_LAT - 1);
  localparam bf_idx_t    LAST_BF    = 2'(BF_PER_STAGE - 1);
  localparam stage_t     LAST_STAGE = 2'(LOG2N - 1);

  state_t  r_state;
  stage_t  r_stage;
  bf_idx_t r_k;
  logic [1:0] r_drain_cnt;
  logic    r_ready;
  logic    r_busy;
  logic    r_load_en;
  logic    r_bf_valid;
  addr_t   r_bf_addr_a;
  addr_t   r_bf_addr_b;
  tw_t     r_tw_idx;
  logic    r_busy_err;

  logic    w_req;
  bf_idx_t w_k_next;
  stage_t  w_stage_next;

  assign w_req        = write | start;
  assign w_k_next     = r_k + 2'd1;
  assign w_stage_next = r_stage + 2'd1;

  // Main FSM: state, counters and every registered control output. Outputs
  // are loaded with the values for the state being entered, so the issue
  // strobe appears in the same cycle the FSM is in RUN.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_stage     <= 2'd0;
      r_k         <= 2'd0;
      r_drain_cnt <= 2'd0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_load_en   <= 1'b0;
      r_bf_valid  <= 1'b0;
      r_bf_addr_a <= 3'd0;
      r_bf_addr_b <= 3'd0;
      r_tw_idx    <= 2'd0;
      r_busy_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // A combined write+start loads first; the load is single-cycle so
          // the run can begin on the very same next cycle.
          r_load_en <= write;
          if (start) begin
            r_state     <= ST_RUN;
            r_stage     <= 2'd0;
            r_k         <= 2'd0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            r_bf_valid  <= 1'b1;
            r_bf_addr_a <= calc_addr_a(2'd0, 2'd0);
            r_bf_addr_b <= calc_addr_b(2'd0, 2'd0);
            r_tw_idx    <= calc_tw(2'd0, 2'd0);
          end else if (write) begin
            r_ready <= 1'b0;
          end
        end

        ST_RUN: begin
          r_load_en <= 1'b0;
          if (w_req) begin
            r_busy_err <= 1'b1;
          end
          if (r_k == LAST_BF) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= 2'd0;
            r_bf_valid  <= 1'b0;
            r_bf_addr_a <= 3'd0;
            r_bf_addr_b <= 3'd0;
            r_tw_idx    <= 2'd0;
          end else begin
            r_k         <= w_k_next;
            r_bf_valid  <= 1'b1;
            r_bf_addr_a <= calc_addr_a(r_stage, w_k_next);
            r_bf_addr_b <= calc_addr_b(r_stage, w_k_next);
            r_tw_idx    <= calc_tw(r_stage, w_k_next);
          end
        end

        ST_DRAIN: begin
          r_load_en <= 1'b0;
          if (w_req) begin
            r_busy_err <= 1'b1;
          end
          if (r_drain_cnt == DRAIN_LAST) begin
            if (r_stage == LAST_STAGE) begin
              r_state <= ST_DONE;
              r_stage <= 2'd0;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state     <= ST_RUN;
              r_stage     <= w_stage_next;
              r_k         <= 2'd0;
              r_bf_valid  <= 1'b1;
              r_bf_addr_a <= calc_addr_a(w_stage_next, 2'd0);
              r_bf_addr_b <= calc_addr_b(w_stage_next, 2'd0);
              r_tw_idx    <= calc_tw(w_stage_next, 2'd0);
            end
          end else begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_ready    <= 1'b0;
          r_busy     <= 1'b0;
          r_load_en  <= 1'b0;
          r_bf_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign busy      = r_busy;
  assign load_en   = r_load_en;
  assign bf_valid  = r_bf_valid;
  assign bf_addr_a = r_bf_addr_a;
  assign bf_addr_b = r_bf_addr_b;
  assign tw_idx    = r_tw_idx;
  assign bf_stage  = r_stage;
  assign busy_err  = r_busy_err;

`ifdef FFT8_SCALE_EN
  assign bf_scale = r_bf_valid;
`else
  assign bf_scale = 1'b0;
`endif

  fft8_wb_delay #(
    .BF_LAT (BF_LAT)
  ) u_wb_delay (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .i_valid  (r_bf_valid),
    .i_addr_a (r_bf_addr_a),
    .i_addr_b (r_bf_addr_b),
    .o_valid  (wb_en),
    .o_addr_a (wb_addr_a),
    .o_addr_b (wb_addr_b)
  );

endmodule

// File: tb/tb_fft8_sequencer.sv
// Directed, table-driven bench for fft8_sequencer (BF_LAT=2 main instance,
// plus a BF_LAT=4 instance for the latency/scale check).
module tb_fft8_sequencer;

  logic       CLK;
  logic       RST_N;
  logic       write, start;
  logic       ready, busy, load_en, bf_valid, bf_scale, wb_en, busy_err;
  logic [2:0] bf_addr_a, bf_addr_b, wb_addr_a, wb_addr_b;
  logic [1:0] tw_idx, bf_stage;

  logic       write4, start4;
  logic       ready4, busy4, load_en4, bf_valid4, bf_scale4, wb_en4, busy_err4;
  logic [2:0] bf_addr_a4, bf_addr_b4, wb_addr_a4, wb_addr_b4;
  logic [1:0] tw_idx4, bf_stage4;

  int n_cmp = 0;
  int n_err = 0;

  fft8_sequencer #(.BF_LAT(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .write(write), .start(start),
    .ready(ready), .busy(busy), .load_en(load_en), .bf_valid(bf_valid),
    .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b), .tw_idx(tw_idx),
    .bf_stage(bf_stage), .bf_scale(bf_scale), .wb_en(wb_en),
    .wb_addr_a(wb_addr_a), .wb_addr_b(wb_addr_b), .busy_err(busy_err)
  );

  fft8_sequencer #(.BF_LAT(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .write(write4), .start(start4),
    .ready(ready4), .busy(busy4), .load_en(load_en4), .bf_valid(bf_valid4),
    .bf_addr_a(bf_addr_a4), .bf_addr_b(bf_addr_b4), .tw_idx(tw_idx4),
    .bf_stage(bf_stage4), .bf_scale(bf_scale4), .wb_en(wb_en4),
    .wb_addr_a(wb_addr_a4), .wb_addr_b(wb_addr_b4), .busy_err(busy_err4)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start (optionally with write) in cycle 0, then follow until ready.
  task automatic run_wait(input logic wr, output int lat, output int nwb,
                          output logic ld1, output logic bfv1);
    @(negedge CLK);
    start = 1'b1;
    write = wr;
    @(negedge CLK);
    start = 1'b0;
    write = 1'b0;
    ld1  = load_en;
    bfv1 = bf_valid;
    lat  = 1;
    nwb  = 0;
    while (!ready && lat < 60) begin
      nwb += int'(wb_en);
      @(negedge CLK);
      lat++;
    end
  endtask

  typedef struct {
    logic       bfv;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
    logic [1:0] stg;
    logic       wbe;
    logic [2:0] wa;
    logic [2:0] wb;
    logic       rdy;
    logic       bsy;
  } vec_t;

  vec_t tbl [1:20];

  initial begin
    int   lat, nwb, nbv4, nwb4, cyc;
    logic ld1, bfv1, exp_v, exp_s;

    //             bfv   a     b     tw    stg   wbe   wa    wb    rdy   bsy
    tbl[1]  = '{1'b1, 3'd0, 3'd1, 2'd0, 2'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 3'd2, 3'd3, 2'd0, 2'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 3'd4, 3'd5, 2'd0, 2'd0, 1'b1, 3'd0, 3'd1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 3'd6, 3'd7, 2'd0, 2'd0, 1'b1, 3'd2, 3'd3, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 3'd0, 3'd0, 2'd0, 2'd0, 1'b1, 3'd4, 3'd5, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 3'd0, 3'd0, 2'd0, 2'd0, 1'b1, 3'd6, 3'd7, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 3'd0, 3'd2, 2'd0, 2'd1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 3'd1, 3'd3, 2'd2, 2'd1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 3'd4, 3'd6, 2'd0, 2'd1, 1'b1, 3'd0, 3'd2, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 3'd5, 3'd7, 2'd2, 2'd1, 1'b1, 3'd1, 3'd3, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 3'd0, 3'd0, 2'd0, 2'd1, 1'b1, 3'd4, 3'd6, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 3'd0, 3'd0, 2'd0, 2'd1, 1'b1, 3'd5, 3'd7, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 3'd0, 3'd4, 2'd0, 2'd2, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 3'd1, 3'd5, 2'd1, 2'd2, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 3'd2, 3'd6, 2'd2, 2'd2, 1'b1, 3'd0, 3'd4, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 3'd3, 3'd7, 2'd3, 2'd2, 1'b1, 3'd1, 3'd5, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 3'd0, 3'd0, 2'd0, 2'd2, 1'b1, 3'd2, 3'd6, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 3'd0, 3'd0, 2'd0, 2'd2, 1'b1, 3'd3, 3'd7, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 3'd0, 3'd0, 2'd0, 2'd0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 3'd0, 3'd0, 2'd0, 2'd0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};

    RST_N  = 1'b0;
    write  = 1'b0;
    start  = 1'b0;
    write4 = 1'b0;
    start4 = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_ready", ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_load_en", load_en, 1'b0);
    chk("rst_bf_valid", bf_valid, 1'b0);
    chk("rst_wb_en", wb_en, 1'b0);
    chk("rst_busy_err", busy_err, 1'b0);
    chk("rst_addr", {bf_addr_a, bf_addr_b, wb_addr_a, wb_addr_b}, 12'd0);
    chk("rst_tw_stage", {tw_idx, bf_stage, bf_scale}, 5'd0);
    RST_N = 1'b1;

    // Write pulse from IDLE: one-cycle load strobe, no run
    @(negedge CLK);
    write = 1'b1;
    @(negedge CLK);
    write = 1'b0;
    chk("wr_load_en_c1", load_en, 1'b1);
    chk("wr_ready_c1", ready, 1'b0);
    chk("wr_busy_c1", busy, 1'b0);
    chk("wr_bf_valid_c1", bf_valid, 1'b0);
    @(negedge CLK);
    chk("wr_load_en_c2", load_en, 1'b0);
    chk("wr_busy_c2", busy, 1'b0);

    // write+start together from IDLE
    run_wait(1'b1, lat, nwb, ld1, bfv1);
    chk("ws_load_en_c1", ld1, 1'b1);
    chk("ws_bf_valid_c1", bfv1, 1'b1);
    chk("ws_latency", lat, 32'd19);
    chk("ws_wb_count", nwb, 32'd12);

    // Full table run from DONE
    @(negedge CLK);
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      start = 1'b0;
      chk($sformatf("tbl%0d_bf_valid", c), bf_valid, tbl[c].bfv);
      chk($sformatf("tbl%0d_addr_a", c), bf_addr_a, tbl[c].a);
      chk($sformatf("tbl%0d_addr_b", c), bf_addr_b, tbl[c].b);
      chk($sformatf("tbl%0d_tw", c), tw_idx, tbl[c].tw);
      chk($sformatf("tbl%0d_stage", c), bf_stage, tbl[c].stg);
      chk($sformatf("tbl%0d_wb_en", c), wb_en, tbl[c].wbe);
      chk($sformatf("tbl%0d_wb_a", c), wb_addr_a, tbl[c].wa);
      chk($sformatf("tbl%0d_wb_b", c), wb_addr_b, tbl[c].wb);
      chk($sformatf("tbl%0d_ready", c), ready, tbl[c].rdy);
      chk($sformatf("tbl%0d_busy", c), busy, tbl[c].bsy);
      chk($sformatf("tbl%0d_load_en", c), load_en, 1'b0);
`ifdef FFT8_SCALE_EN
      chk($sformatf("tbl%0d_scale", c), bf_scale, tbl[c].bfv);
`else
      chk($sformatf("tbl%0d_scale", c), bf_scale, 1'b0);
`endif
    end
    chk("tbl_busy_err", busy_err, 1'b0);

    // start during a run at cycle 8 is ignored and flagged
    @(negedge CLK);
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (c == 7) chk("ign_busy_err_c7", busy_err, 1'b0);
      if (c == 9) chk("ign_busy_err_c9", busy_err, 1'b1);
      if (c == 18) chk("ign_ready_c18", ready, 1'b0);
      if (c == 19) chk("ign_ready_c19", ready, 1'b1);
      if (c == 20) chk("ign_busy_err_c20", busy_err, 1'b1);
      start = (c == 8);
    end

    // Reset mid-transform at cycle 10
    @(negedge CLK);
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      start = 1'b0;
    end
    chk("mid_busy_before", busy, 1'b1);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_bf_valid", bf_valid, 1'b0);
    chk("mid_rst_wb_en", wb_en, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", ready, 1'b0);
    chk("mid_rst_busy_err", busy_err, 1'b0);
    chk("mid_rst_addr", {bf_addr_a, bf_addr_b, wb_addr_a, wb_addr_b, tw_idx}, 14'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    nwb = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      nwb += int'(wb_en) + int'(bf_valid) + int'(busy);
    end
    chk("post_rst_quiet", nwb, 32'd0);
    run_wait(1'b0, lat, nwb, ld1, bfv1);
    chk("post_rst_bf_valid_c1", bfv1, 1'b1);
    chk("post_rst_latency", lat, 32'd19);
    chk("post_rst_wb_count", nwb, 32'd12);

    // BF_LAT=4 instance: latency and scale output
    @(negedge CLK);
    start4 = 1'b1;
    @(negedge CLK);
    start4 = 1'b0;
    cyc  = 1;
    nbv4 = 0;
    nwb4 = 0;
    while (!ready4 && cyc < 60) begin
      exp_v = (cyc >= 1) && (cyc <= 24) && (((cyc - 1) % 8) < 4);
`ifdef FFT8_SCALE_EN
      exp_s = exp_v;
`else
      exp_s = 1'b0;
`endif
      chk($sformatf("l4_c%0d_bf_valid", cyc), bf_valid4, exp_v);
      chk($sformatf("l4_c%0d_scale", cyc), bf_scale4, exp_s);
      nbv4 += int'(bf_valid4);
      nwb4 += int'(wb_en4);
      @(negedge CLK);
      cyc++;
    end
    chk("l4_latency", cyc, 32'd25);
    chk("l4_bf_count", nbv4, 32'd12);
    chk("l4_wb_count", nwb4, 32'd12);
    chk("l4_busy_done", busy4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
